// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment display driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [5:0] DIG_OFF  = 6'h3F;

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD-to-segment decoder with decimal point, active-low output.
// Values above 9 render as a dash so a corrupt counter digit is visible.
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] val_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  logic [6:0] glyph;

  always_comb begin
    glyph = SEG_DASH;
    case (val_i)
      4'd0: glyph = SEG_0;
      4'd1: glyph = SEG_1;
      4'd2: glyph = SEG_2;
      4'd3: glyph = SEG_3;
      4'd4: glyph = SEG_4;
      4'd5: glyph = SEG_5;
      4'd6: glyph = SEG_6;
      4'd7: glyph = SEG_7;
      4'd8: glyph = SEG_8;
      4'd9: glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
    seg_o = {~dp_i, glyph};
  end

endmodule

// File: rtl/seg7_scan.sv
// Six-digit multiplexed display scanner: per-frame digit snapshot, slot timing
// with anti-ghosting blank, blink and decimal-point control, registered outputs.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK    = 16,
  parameter int LZ_BLANK = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       en1hz,
  input  logic [3:0] SEC_L,
  input  logic [2:0] SEC_H,
  input  logic [3:0] MIN_L,
  input  logic [2:0] MIN_H,
  input  logic [3:0] HOUR_L,
  input  logic [1:0] HOUR_H,
  input  logic [5:0] BLINK_MASK,
  input  logic [5:0] DP_EN,
  output logic [7:0] SEG,
  output logic [5:0] DIGIT
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);

  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [2:0]                     idx_q, idx_d;
  logic                           ph_q, ph_d;
  logic                           loadPend_q;
  logic [NUM_DIGITS-1:0][3:0]     snap_q, snap_d;
  logic [7:0]                     seg_q, seg_d;
  logic [5:0]                     digit_q, digit_d;

  logic                           cntWrap;
  logic                           lzBlank;
  logic                           lit;
  logic [3:0]                     curVal;
  logic [7:0]                     decSeg;
  logic [NUM_DIGITS-1:0][3:0]     liveDigits;

  assign liveDigits = {{2'b00, HOUR_H}, HOUR_L, {1'b0, MIN_H}, MIN_L, {1'b0, SEC_H}, SEC_L};

  seg7_dec u_dec (
    .val_i (curVal),
    .dp_i  (DP_EN[idx_q]),
    .seg_o (decSeg)
  );

  always_comb begin
    cntWrap = (cnt_q == CNT_LAST);
    cnt_d   = cntWrap ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    if (cntWrap) idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    ph_d    = ph_q ^ en1hz;

    // Snapshot only at the frame boundary (or right after reset) so a frame is never mixed.
    snap_d  = snap_q;
    if (loadPend_q || (cntWrap && idx_q == IDX_LAST)) snap_d = liveDigits;

    curVal  = snap_q[idx_q];
    lzBlank = (LZ_BLANK != 0) && (idx_q == IDX_LAST) && (snap_q[NUM_DIGITS-1] == 4'd0);
    lit     = EN && (cnt_q >= CNT_BLANK) && !(ph_q && BLINK_MASK[idx_q]) && !lzBlank;

    digit_d = lit ? ~(6'b000001 << idx_q) : DIG_OFF;
    seg_d   = lit ? decSeg : SEG_OFF;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      ph_q       <= 1'b0;
      loadPend_q <= 1'b1;
      snap_q     <= '0;
      seg_q      <= SEG_OFF;
      digit_q    <= DIG_OFF;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ph_q       <= ph_d;
      loadPend_q <= 1'b0;
      snap_q     <= snap_d;
      seg_q      <= seg_d;
      digit_q    <= digit_d;
    end
  end

  assign SEG   = seg_q;
  assign DIGIT = digit_q;

endmodule
